// File: rtl/lfsr_pkg.sv
// Shared types and default feedback masks for the parametrised LFSR word generator.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIBO   = 1'b0,
        LFSR_GALOIS = 1'b1
    } lfsr_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } lfsr_fsm_e;

    localparam int LFSR_MIN_WIDTH = 8;
    localparam int LFSR_MAX_WIDTH = 64;

    // Widths without a tabulated maximal polynomial get a non-zero but non-maximal
    // mask; such instances should pass TAPS explicitly.
    function automatic logic [63:0] default_taps(input int width);
        logic [63:0] taps_v;
        case (width)
            8:       taps_v = 64'h0000_0000_0000_00B8;
            16:      taps_v = 64'h0000_0000_0000_B400;
            32:      taps_v = 64'h0000_0000_8020_0003;
            64:      taps_v = 64'hD800_0000_0000_0000;
            default: taps_v = 64'h0000_0000_0000_0003 << (width - 2);
        endcase
        return taps_v;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Request/seed inputs and valid/ready output handshake of lfsr_gen.
interface lfsr_gen_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] num;
    logic             wrap;
    logic             lockup;

    modport master (
        output en, load, seed, out_ready,
        input  out_valid, num, wrap, lockup
    );

    modport slave (
        input  en, load, seed, out_ready,
        output out_valid, num, wrap, lockup
    );
endinterface

// File: rtl/lfsr_step.sv
// One combinational LFSR shift in Fibonacci or Galois form.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter lfsr_mode_e       MODE  = LFSR_FIBO
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    generate
        if (MODE == LFSR_GALOIS) begin : g_galois
            assign nxt = {1'b0, cur[WIDTH-1:1]} ^ (cur[0] ? TAPS : {WIDTH{1'b0}});
        end else begin : g_fibo
            assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Throttleable PRBS source: STEP LFSR shifts per accepted word, seed loading with
// zero-seed substitution, and wrap detection against the last loaded seed.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter lfsr_mode_e       MODE         = LFSR_FIBO,
    parameter int               STEP         = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic       clk,
    input  logic       rst_n,
    lfsr_gen_if.slave  bus
);

    generate
        if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be in 8..64");
        end
        if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
            $error("lfsr_gen: STEP must be in 1..WIDTH");
        end
        if (TAPS == {WIDTH{1'b0}}) begin : g_bad_taps
            $error("lfsr_gen: TAPS must be non-zero");
        end
        if (DEFAULT_SEED == {WIDTH{1'b0}}) begin : g_bad_seed
            $error("lfsr_gen: DEFAULT_SEED must be non-zero");
        end
    endgenerate

    lfsr_fsm_e        fsm_r;
    lfsr_fsm_e        fsm_next_s;
    logic [WIDTH-1:0] lfsr_r;
    logic [WIDTH-1:0] lfsr_next_s;
    logic [WIDTH-1:0] ref_seed_r;
    logic [WIDTH-1:0] ref_seed_next_s;
    logic             valid_r;
    logic             wrap_r;
    logic             wrap_next_s;
    logic             lockup_r;
    logic             lockup_next_s;
    logic             accept_s;
    logic [WIDTH-1:0] adv_s;

    // Each stage feeds the next so all STEP shifts settle within one clock.
    generate
        for (genvar i = 0; i < STEP; i++) begin : g_step
            logic [WIDTH-1:0] cur_s;
            logic [WIDTH-1:0] nxt_s;
            if (i == 0) begin : g_first
                assign cur_s = lfsr_r;
            end else begin : g_chain
                assign cur_s = g_step[i-1].nxt_s;
            end
            lfsr_step #(
                .WIDTH (WIDTH),
                .TAPS  (TAPS),
                .MODE  (MODE)
            ) u_step (
                .cur (cur_s),
                .nxt (nxt_s)
            );
        end
    endgenerate

    assign adv_s = g_step[STEP-1].nxt_s;

    // Next-state logic: load outranks accept and en, and voids a coincident accept.
    always_comb begin
        fsm_next_s      = fsm_r;
        lfsr_next_s     = lfsr_r;
        ref_seed_next_s = ref_seed_r;
        wrap_next_s     = 1'b0;
        lockup_next_s   = 1'b0;
        accept_s        = (fsm_r == ST_VALID) && bus.out_ready;
        if (bus.load) begin
            fsm_next_s = ST_IDLE;
            if (bus.seed == {WIDTH{1'b0}}) begin
                lfsr_next_s     = DEFAULT_SEED;
                ref_seed_next_s = DEFAULT_SEED;
                lockup_next_s   = 1'b1;
            end else begin
                lfsr_next_s     = bus.seed;
                ref_seed_next_s = bus.seed;
            end
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (bus.en) begin
                        fsm_next_s = ST_VALID;
                    end else begin
                        fsm_next_s = ST_IDLE;
                    end
                end
                ST_VALID: begin
                    if (accept_s) begin
                        lfsr_next_s = adv_s;
                        wrap_next_s = (adv_s == ref_seed_r);
                        fsm_next_s  = bus.en ? ST_VALID : ST_IDLE;
                    end else begin
                        fsm_next_s = ST_VALID;
                    end
                end
                default: begin
                    fsm_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset is synchronous and overrides load/accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_r      <= ST_IDLE;
            lfsr_r     <= DEFAULT_SEED;
            ref_seed_r <= DEFAULT_SEED;
            valid_r    <= 1'b0;
            wrap_r     <= 1'b0;
            lockup_r   <= 1'b0;
        end else begin
            fsm_r      <= fsm_next_s;
            lfsr_r     <= lfsr_next_s;
            ref_seed_r <= ref_seed_next_s;
            valid_r    <= (fsm_next_s == ST_VALID);
            wrap_r     <= wrap_next_s;
            lockup_r   <= lockup_next_s;
        end
    end

    assign bus.out_valid = valid_r;
    assign bus.num       = lfsr_r;
    assign bus.wrap      = wrap_r;
    assign bus.lockup    = lockup_r;

endmodule
